// File: rtl/ifmap_skew_feeder_pkg.sv
// Shared definitions for the ifmap read feeder and the ofmap write buffer:
// default geometry, FSM encoding and MSB-first lane slicing.
package ifmap_skew_feeder_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int PE_SIZE_DEF        = 14;
    localparam int MEM_ADDR_WIDTH_DEF = 10;
    localparam int MEM_DATA_WIDTH_DEF = DATA_WIDTH_DEF * PE_SIZE_DEF;
    localparam int ROW_CNT_DEF        = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // Lane 0 occupies the most significant element of a packed word.
    function automatic int lane_msb(input int lane, input int data_width, input int pe_size);
        return data_width * pe_size - 1 - lane * data_width;
    endfunction

endpackage

// File: rtl/ifmap_skew_feeder_skew_delay_line.sv
// Data+valid shift register of DEPTH stages with synchronous active-low reset.
// DEPTH=0 degenerates to a plain wire-through.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             vin,
    output logic [WIDTH-1:0] dout,
    output logic             vout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
            assign vout = vin;
        end else begin : g_shift
            logic [WIDTH-1:0] data_sr [DEPTH];
            logic [DEPTH-1:0] valid_sr;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        data_sr[j] <= '0;
                    end
                    valid_sr <= '0;
                end else begin
                    data_sr[0]  <= din;
                    valid_sr[0] <= vin;
                    for (int j = 1; j < DEPTH; j++) begin
                        data_sr[j]  <= data_sr[j-1];
                        valid_sr[j] <= valid_sr[j-1];
                    end
                end
            end

            assign dout = data_sr[DEPTH-1];
            assign vout = valid_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Reads ROW_CNT consecutive BRAM words and feeds them into the PE array with a
// diagonal skew: lane i lags lane 0 by i cycles, invalid lanes forced to zero.
module ifmap_skew_feeder
    import ifmap_skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int PE_SIZE        = PE_SIZE_DEF,
    parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
    parameter int MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF,
    parameter int ROW_CNT        = ROW_CNT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [MEM_ADDR_WIDTH-1:0]     base_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0]     mem_q_i,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic                          mem_ce_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] row_o,
    output logic [PE_SIZE-1:0]            row_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output fsm_state_t                    fsm_state
);

    localparam int RC_W = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
    localparam int DC_W = $clog2(PE_SIZE + 1);

    logic [RC_W-1:0]           rd_cnt;
    logic [DC_W-1:0]           drn_cnt;
    logic                      ce_d;
    logic                      s0_valid;
    logic [MEM_DATA_WIDTH-1:0] s0_data;

    assign mem_we_o = 1'b0;

    // start_i is a one-cycle request with no ready: it is taken only in IDLE
    // and dropped (not queued) in every other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_state  <= ST_IDLE;
            mem_addr_o <= '0;
            mem_ce_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rd_cnt     <= '0;
            drn_cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            case (fsm_state)
                ST_IDLE: begin
                    if (start_i) begin
                        fsm_state  <= ST_READ;
                        mem_addr_o <= base_addr_i;
                        mem_ce_o   <= 1'b1;
                        busy_o     <= 1'b1;
                        rd_cnt     <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_cnt == RC_W'(ROW_CNT - 1)) begin
                        fsm_state <= ST_DRAIN;
                        mem_ce_o  <= 1'b0;
                        drn_cnt   <= '0;
                    end else begin
                        mem_addr_o <= mem_addr_o + MEM_ADDR_WIDTH'(1);
                        rd_cnt     <= rd_cnt + RC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // PE_SIZE+1 cycles: BRAM latency plus the deepest lane.
                    if (drn_cnt == DC_W'(PE_SIZE)) begin
                        fsm_state <= ST_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        drn_cnt <= drn_cnt + DC_W'(1);
                    end
                end
                ST_DONE: begin
                    fsm_state <= ST_IDLE;
                end
                default: begin
                    fsm_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 0 captures mem_q_i only when it carries read data, so bus garbage
    // never enters the skew lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ce_d     <= 1'b0;
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            ce_d     <= mem_ce_o;
            s0_valid <= ce_d;
            s0_data  <= ce_d ? mem_q_i : '0;
        end
    end

    generate
        for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
            localparam int MSB = lane_msb(i, DATA_WIDTH, PE_SIZE);
            logic [DATA_WIDTH-1:0] lane_data;
            logic                  lane_valid;

            skew_delay_line #(
                .DEPTH(i),
                .WIDTH(DATA_WIDTH)
            ) u_delay (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (s0_data[MSB -: DATA_WIDTH]),
                .vin  (s0_valid),
                .dout (lane_data),
                .vout (lane_valid)
            );

            assign row_o[MSB -: DATA_WIDTH] = lane_valid ? lane_data : '0;
            assign row_valid_o[i]           = lane_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Bench for ifmap_skew_feeder: a small (PE_SIZE=4, ROW_CNT=3) instance and a
// default-size instance, checked against a table and a closed-form timing model.
module tb_ifmap_skew_feeder;
    import ifmap_skew_feeder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- small instance ----------------
    logic        s_start;
    logic [9:0]  s_base;
    logic [31:0] s_q;
    logic [9:0]  s_addr;
    logic        s_ce, s_we;
    logic [31:0] s_row;
    logic [3:0]  s_valid;
    logic        s_busy, s_done;
    fsm_state_t  s_state;

    ifmap_skew_feeder #(
        .DATA_WIDTH(8), .PE_SIZE(4), .MEM_ADDR_WIDTH(10),
        .MEM_DATA_WIDTH(32), .ROW_CNT(3)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .base_addr_i(s_base),
        .mem_q_i(s_q), .mem_addr_o(s_addr), .mem_ce_o(s_ce), .mem_we_o(s_we),
        .row_o(s_row), .row_valid_o(s_valid), .busy_o(s_busy), .done_o(s_done),
        .fsm_state(s_state)
    );

    // ---------------- default instance ----------------
    logic         f_start;
    logic [9:0]   f_base;
    logic [111:0] f_q;
    logic [9:0]   f_addr;
    logic         f_ce, f_we;
    logic [111:0] f_row;
    logic [13:0]  f_valid;
    logic         f_busy, f_done;
    fsm_state_t   f_state;

    ifmap_skew_feeder dut_full (
        .clk(clk), .rst_n(rst_n), .start_i(f_start), .base_addr_i(f_base),
        .mem_q_i(f_q), .mem_addr_o(f_addr), .mem_ce_o(f_ce), .mem_we_o(f_we),
        .row_o(f_row), .row_valid_o(f_valid), .busy_o(f_busy), .done_o(f_done),
        .fsm_state(f_state)
    );

    // ---------------- BRAM models (garbage on the bus when not reading) ----
    logic [31:0]  mem_s [1024];
    logic [111:0] mem_f [1024];

    always @(posedge clk) begin
        s_q <= s_ce ? mem_s[s_addr] : $urandom;
        f_q <= f_ce ? mem_f[f_addr] : 112'({$urandom, $urandom, $urandom, $urandom});
    end

    // ---------------- scoreboard state ----------------
    logic [111:0] words [64];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic        start;
        logic [9:0]  addr;
        logic        ce;
        logic [31:0] row;
        logic [3:0]  valid;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected outputs rel cycles after the start_i cycle, derived from the
    // timing rules: word k addressed at 1+k, lane i of word k shown at 3+k+i.
    task automatic model_check(input string tag, input int rel, input int pe, input int rows,
                               input int base, input logic [9:0] a_addr, input logic a_ce,
                               input logic a_we, input logic [111:0] a_row,
                               input logic [13:0] a_valid, input logic a_busy, input logic a_done);
        logic         e_ce, e_busy, e_done;
        logic [111:0] e_row;
        logic [13:0]  e_valid;
        logic [9:0]   e_addr;
        int           k, msb;
        e_ce    = (rel >= 1) && (rel <= rows);
        e_busy  = (rel >= 1) && (rel <= rows + pe + 1);
        e_done  = (rel == rows + pe + 2);
        e_addr  = 10'(base + rel - 1);
        e_row   = '0;
        e_valid = '0;
        for (int i = 0; i < pe; i++) begin
            k = rel - 3 - i;
            if (k >= 0 && k < rows) begin
                msb = pe * 8 - 1 - i * 8;
                e_valid[i]       = 1'b1;
                e_row[msb -: 8]  = words[k][msb -: 8];
            end
        end
        chk({tag, "_ce"},    a_ce,    e_ce);
        chk({tag, "_we"},    a_we,    1'b0);
        chk({tag, "_busy"},  a_busy,  e_busy);
        chk({tag, "_done"},  a_done,  e_done);
        chk({tag, "_valid"}, a_valid, e_valid);
        chk({tag, "_row"},   a_row,   e_row);
        if (e_ce) chk({tag, "_addr"}, a_addr, e_addr);
    endtask

    task automatic load_small_words(input int base);
        logic [3:0] hi, lo;
        for (int k = 0; k < 64; k++) begin
            words[k] = '0;
            for (int i = 0; i < 4; i++) begin
                hi = 4'(k);
                lo = 4'(i + 1);
                words[k][31 - 8*i -: 8] = {hi, lo};
            end
        end
        for (int k = 0; k < 3; k++) mem_s[10'(base + k)] = words[k][31:0];
    endtask

    initial begin
        rst_n   = 1'b0;
        s_start = 1'b0;
        s_base  = '0;
        f_start = 1'b0;
        f_base  = '0;
        for (int a = 0; a < 1024; a++) begin
            mem_s[a] = $urandom;
            mem_f[a] = 112'({$urandom, $urandom, $urandom, $urandom});
        end

        tbl[0]  = '{1'b1, 10'd0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 10'd5, 1'b1, 32'h00000000, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 10'd6, 1'b1, 32'h00000000, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 10'd7, 1'b1, 32'h01000000, 4'b0001, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 10'd0, 1'b0, 32'h11020000, 4'b0011, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 10'd0, 1'b0, 32'h21120300, 4'b0111, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 10'd0, 1'b0, 32'h00221304, 4'b1110, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 10'd0, 1'b0, 32'h00002314, 4'b1100, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 10'd0, 1'b0, 32'h00000024, 4'b1000, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 10'd0, 1'b0, 32'h00000000, 4'b0000, 1'b0, 1'b1};
        for (int r = 10; r < 15; r++) tbl[r] = '{1'b0, 10'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // reset state
        chk("rst_small_state", s_state, ST_IDLE);
        chk("rst_full_state",  f_state, ST_IDLE);
        chk("rst_full_addr",   f_addr,  10'd0);
        model_check("rst_full", -1000, 14, 64, 0, f_addr, f_ce, f_we, f_row, f_valid, f_busy, f_done);

        // table: basic block, skew alignment, ignored restarts in READ and DONE
        s_base = 10'd5;
        load_small_words(5);
        cyc = 0;
        for (int r = 0; r < 15; r++) begin
            chk("tbl_ce",    s_ce,    tbl[r].ce);
            chk("tbl_we",    s_we,    1'b0);
            chk("tbl_row",   s_row,   tbl[r].row);
            chk("tbl_valid", s_valid, tbl[r].valid);
            chk("tbl_busy",  s_busy,  tbl[r].busy);
            chk("tbl_done",  s_done,  tbl[r].done);
            if (tbl[r].ce || r == 0) chk("tbl_addr", s_addr, tbl[r].addr);
            s_start = tbl[r].start;
            tick();
        end
        s_start = 1'b0;
        chk("tbl_end_state", s_state, ST_IDLE);

        // address wrap through 0
        s_base = 10'd1022;
        load_small_words(1022);
        cyc = 0;
        for (int rel = 0; rel < 13; rel++) begin
            model_check("wrap", rel, 4, 3, 1022, s_addr, s_ce, s_we,
                        {80'b0, s_row}, {10'b0, s_valid}, s_busy, s_done);
            s_start = (rel == 0);
            tick();
        end

        // reset in the middle of a block, then a clean restart
        s_base = 10'd5;
        load_small_words(5);
        cyc = 0;
        for (int rel = 0; rel < 5; rel++) begin
            model_check("prerst", rel, 4, 3, 5, s_addr, s_ce, s_we,
                        {80'b0, s_row}, {10'b0, s_valid}, s_busy, s_done);
            s_start = (rel == 0);
            if (rel == 4) rst_n = 1'b0;
            tick();
        end
        rst_n = 1'b1;
        model_check("postrst", -1000, 4, 3, 5, s_addr, s_ce, s_we,
                    {80'b0, s_row}, {10'b0, s_valid}, s_busy, s_done);
        chk("postrst_addr",  s_addr,  10'd0);
        chk("postrst_state", s_state, ST_IDLE);
        tick();
        for (int rel = 0; rel < 13; rel++) begin
            model_check("restart", rel, 4, 3, 5, s_addr, s_ce, s_we,
                        {80'b0, s_row}, {10'b0, s_valid}, s_busy, s_done);
            s_start = (rel == 0);
            tick();
        end

        // default geometry, random data, back-to-back blocks, random ignored starts
        begin
            int base;
            base = 0;
            for (int b = 0; b < 3; b++) begin
                base = (b == 2) ? 1000 : int'($urandom_range(0, 1023));
                f_base = 10'(base);
                for (int k = 0; k < 64; k++) begin
                    words[k] = 112'({$urandom, $urandom, $urandom, $urandom});
                    mem_f[10'(base + k)] = words[k];
                end
                cyc = 0;
                for (int rel = 0; rel < 81; rel++) begin
                    model_check("full", rel, 14, 64, base, f_addr, f_ce, f_we,
                                f_row, f_valid, f_busy, f_done);
                    f_start = (rel == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                    tick();
                end
            end
            f_start = 1'b0;
            for (int rel = 81; rel < 87; rel++) begin
                model_check("full_tail", rel, 14, 64, base, f_addr, f_ce, f_we,
                            f_row, f_valid, f_busy, f_done);
                tick();
            end
            chk("full_end_state", f_state, ST_IDLE);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
